axi_ad7124_seq: RTL and testbench

//  Conversion sequencer in front of the AD7124 frame buffer. Waits for ADC RDY, then issues
//  one data-register read (cmd + 4 bytes: 24-bit data + status) per channel over the SPI engine.

---
 rtl/axi_ad7124_pkg.sv | 27 ++
 rtl/axi_ad7124_seq_if.sv | 27 ++
 rtl/axi_ad7124_rdy_sync.sv | 37 +++
 rtl/axi_ad7124_seq.sv | 196 +++++++++++++++++++
 tb/tb_axi_ad7124_seq.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_ad7124_pkg.sv
// Shared types and constants for the AD7124 conversion sequencer.
// Contents: the sequencer state enum, the data-register read command byte,
// the response length per channel and the dummy byte clocked out while
// reading, plus a helper that tells whether a state belongs to a channel
// transaction.
package axi_ad7124_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_RDY,
    ST_CMD,
    ST_XFER,
    ST_NEXT,
    ST_DONE
  } seq_state_t;

  localparam logic [7:0] AD7124_CMD_RD_DATA  = 8'h42;
  localparam int         AD7124_BYTES_PER_CH = 4;
  localparam logic [7:0] AD7124_DUMMY        = 8'h00;

  // Chip select is held, and response bytes are counted, over CMD and XFER.
  function automatic logic is_xact(seq_state_t s);
    return (s == ST_CMD) || (s == ST_XFER);
  endfunction

endpackage

// File: rtl/axi_ad7124_seq_if.sv
// Bus bundle between the sequencer, the SPI engine and the frame buffer.
// master: sequencer side (drives command bytes, chip-select hold, trigger and
//         forwarded data; receives ready and response bytes).
// slave : engine/buffer side.
interface axi_ad7124_seq_if;
  logic       spi_cs_hold;
  logic       spi_cmd_valid;
  logic       spi_cmd_ready;
  logic [7:0] spi_cmd_data;
  logic       spi_sdi_valid;
  logic [7:0] spi_sdi_data;
  logic       trigger;
  logic       buf_sdi_valid;
  logic [7:0] buf_sdi_data;

  modport master (
    output spi_cs_hold, spi_cmd_valid, spi_cmd_data,
    output trigger, buf_sdi_valid, buf_sdi_data,
    input  spi_cmd_ready, spi_sdi_valid, spi_sdi_data
  );

  modport slave (
    input  spi_cs_hold, spi_cmd_valid, spi_cmd_data,
    input  trigger, buf_sdi_valid, buf_sdi_data,
    output spi_cmd_ready, spi_sdi_valid, spi_sdi_data
  );
endinterface

// File: rtl/axi_ad7124_rdy_sync.sv
// Synchronizes the asynchronous AD7124 DOUT/RDY pin and produces a one-cycle
// pulse on its falling edge (conversion ready).
// Ports: clk, resetn (async active-low), rdy_n (raw pin), rdy_fall (pulse).
module axi_ad7124_rdy_sync (
  input  logic clk,
  input  logic resetn,
  input  logic rdy_n,
  output logic rdy_fall
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;

  always_comb begin
    s1_d   = rdy_n;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  // Reset to the idle (high) level so a pin already low at reset release is
  // reported as one edge at most, never as a glitch train.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign rdy_fall = prev_q & ~s2_q;

endmodule

// File: rtl/axi_ad7124_seq.sv
// AD7124 conversion sequencer. Waits for RDY, then reads the data register
// of each channel (cmd 0x42 + four dummy bytes), forwards the four response
// bytes to the frame buffer and pulses trigger at the start of each frame.
// Ports: clk/resetn; ctrl_enable/continuous/start and timeout_cycles control;
// adc_rdy_n raw pin; busy/frame_done/err_timeout/err_ch status; bus carries
// the SPI engine command/response stream and the buffer data stream.
// Build option: define AXI_AD7124_SEQ_CH_CHECK_EN to compare the status byte
// channel field against the expected channel (err_ch); otherwise err_ch is 0.
//
// state     | meaning
// IDLE      | not sequencing
// START     | trigger pulse, channel counter cleared
// WAIT_RDY  | waiting for RDY falling edge, timeout timer running
// CMD       | sending 0x42 then four dummy bytes
// XFER      | collecting remaining response bytes
// NEXT      | channel boundary: advance, finish frame or stop
// DONE      | frame_done pulse, optional restart
module axi_ad7124_seq
  import axi_ad7124_pkg::*;
#(
  parameter int NUM_CH    = 8,
  parameter int TIMEOUT_W = 20
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 ctrl_enable,
  input  logic                 ctrl_continuous,
  input  logic                 ctrl_start,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  input  logic                 adc_rdy_n,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 err_timeout,
  output logic                 err_ch,
  axi_ad7124_seq_if.master     bus
);

  localparam int         CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [2:0] TX_LAST = 3'(AD7124_BYTES_PER_CH);
  // Response index 0 arrives during the command byte; 1..4 are payload.
  localparam logic [2:0] RX_LAST = 3'(AD7124_BYTES_PER_CH);
  localparam logic [2:0] RX_DONE = 3'(AD7124_BYTES_PER_CH + 1);

  seq_state_t           state_q, state_d;
  logic [CH_W-1:0]      ch_cnt_q, ch_cnt_d;
  logic [2:0]           tx_cnt_q, tx_cnt_d;
  logic [2:0]           rx_cnt_q, rx_cnt_d;
  logic [TIMEOUT_W-1:0] timer_q, timer_d;
  logic                 err_timeout_q, err_timeout_d;
  logic                 buf_valid_q, buf_valid_d;
  logic [7:0]           buf_data_q, buf_data_d;
  logic                 rdy_fall;
  logic                 rx_in;
`ifdef AXI_AD7124_SEQ_CH_CHECK_EN
  logic                 err_ch_q, err_ch_d;
  logic [3:0]           ch_lo;
  assign ch_lo = 4'(ch_cnt_q);
`endif

  axi_ad7124_rdy_sync u_rdy_sync (
    .clk      (clk),
    .resetn   (resetn),
    .rdy_n    (adc_rdy_n),
    .rdy_fall (rdy_fall)
  );

  assign rx_in = is_xact(state_q) && bus.spi_sdi_valid;

  always_comb begin
    state_d       = state_q;
    ch_cnt_d      = ch_cnt_q;
    tx_cnt_d      = tx_cnt_q;
    rx_cnt_d      = rx_cnt_q;
    timer_d       = timer_q;
    err_timeout_d = err_timeout_q;
    buf_valid_d   = rx_in && (rx_cnt_q != 3'd0);
    buf_data_d    = buf_data_q;
`ifdef AXI_AD7124_SEQ_CH_CHECK_EN
    err_ch_d      = err_ch_q;
`endif

    // Response bytes may arrive while commands are still going out, so
    // counting covers both CMD and XFER.
    if (rx_in) begin
      rx_cnt_d   = rx_cnt_q + 3'd1;
      buf_data_d = bus.spi_sdi_data;
`ifdef AXI_AD7124_SEQ_CH_CHECK_EN
      if ((rx_cnt_q == RX_LAST) && (bus.spi_sdi_data[3:0] != ch_lo)) begin
        err_ch_d = 1'b1;
      end
`endif
    end

    case (state_q)
      ST_IDLE: begin
        if (ctrl_start) begin
          err_timeout_d = 1'b0;
`ifdef AXI_AD7124_SEQ_CH_CHECK_EN
          err_ch_d      = 1'b0;
`endif
          if (ctrl_enable) state_d = ST_START;
        end
      end
      ST_START: begin
        ch_cnt_d = '0;
        timer_d  = '0;
        state_d  = ST_WAIT_RDY;
      end
      ST_WAIT_RDY: begin
        timer_d = timer_q + TIMEOUT_W'(1);
        if (rdy_fall) begin
          timer_d  = '0;
          tx_cnt_d = 3'd0;
          rx_cnt_d = 3'd0;
          state_d  = ST_CMD;
        end else if ((timeout_cycles != '0) &&
                     (timer_q == timeout_cycles - TIMEOUT_W'(1))) begin
          err_timeout_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (bus.spi_cmd_ready) begin
          if (tx_cnt_q == TX_LAST) begin
            tx_cnt_d = 3'd0;
            state_d  = ST_XFER;
          end else begin
            tx_cnt_d = tx_cnt_q + 3'd1;
          end
        end
      end
      ST_XFER: begin
        if ((rx_cnt_q == RX_DONE) || (rx_in && (rx_cnt_q == RX_LAST))) begin
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        timer_d = '0;
        if (ch_cnt_q == CH_W'(NUM_CH - 1)) begin
          state_d = ST_DONE;
        end else begin
          ch_cnt_d = ch_cnt_q + CH_W'(1);
          state_d  = ctrl_enable ? ST_WAIT_RDY : ST_IDLE;
        end
      end
      ST_DONE: begin
        state_d = (ctrl_continuous && ctrl_enable) ? ST_START : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      ch_cnt_q      <= '0;
      tx_cnt_q      <= 3'd0;
      rx_cnt_q      <= 3'd0;
      timer_q       <= '0;
      err_timeout_q <= 1'b0;
      buf_valid_q   <= 1'b0;
      buf_data_q    <= 8'h00;
    end else begin
      state_q       <= state_d;
      ch_cnt_q      <= ch_cnt_d;
      tx_cnt_q      <= tx_cnt_d;
      rx_cnt_q      <= rx_cnt_d;
      timer_q       <= timer_d;
      err_timeout_q <= err_timeout_d;
      buf_valid_q   <= buf_valid_d;
      buf_data_q    <= buf_data_d;
    end
  end

`ifdef AXI_AD7124_SEQ_CH_CHECK_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) err_ch_q <= 1'b0;
    else         err_ch_q <= err_ch_d;
  end
  assign err_ch = err_ch_q;
`else
  assign err_ch = 1'b0;
`endif

  assign busy              = (state_q != ST_IDLE);
  assign frame_done        = (state_q == ST_DONE);
  assign err_timeout       = err_timeout_q;
  assign bus.trigger       = (state_q == ST_START);
  assign bus.spi_cs_hold   = is_xact(state_q);
  assign bus.spi_cmd_valid = (state_q == ST_CMD);
  assign bus.spi_cmd_data  = (state_q == ST_CMD && tx_cnt_q == 3'd0) ?
                             AD7124_CMD_RD_DATA : AD7124_DUMMY;
  assign bus.buf_sdi_valid = buf_valid_q;
  assign bus.buf_sdi_data  = buf_data_q;

endmodule

// File: tb/tb_axi_ad7124_seq.sv
module tb_axi_ad7124_seq;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ctrl_enable = 1'b0;
  logic        ctrl_continuous = 1'b0;
  logic        ctrl_start = 1'b0;
  logic [19:0] timeout_cycles = '0;
  logic        adc_rdy_n = 1'b1;
  logic        busy, frame_done, err_timeout, err_ch;

  logic        ready_en = 1'b1;
  logic        rdy_auto = 1'b0;
  int          rdy_cnt = 0;
  logic [7:0]  resp_ctr;

  int          total = 0;
  int          bad = 0;

  int          trig_n, done_n, buf_n, cmd_n, cmd42_n, overlap_n;
  logic [7:0]  buf_log [0:255];
  logic [7:0]  cmd_log [0:255];

  always #5 clk = ~clk;

  axi_ad7124_seq_if bus ();

  axi_ad7124_seq #(.NUM_CH(8), .TIMEOUT_W(20)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .ctrl_enable     (ctrl_enable),
    .ctrl_continuous (ctrl_continuous),
    .ctrl_start      (ctrl_start),
    .timeout_cycles  (timeout_cycles),
    .adc_rdy_n       (adc_rdy_n),
    .busy            (busy),
    .frame_done      (frame_done),
    .err_timeout     (err_timeout),
    .err_ch          (err_ch),
    .bus             (bus)
  );

  // SPI engine model: response k (value k) follows command handshake k by one cycle.
  assign bus.spi_cmd_ready = ready_en;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.spi_sdi_valid <= 1'b0;
      bus.spi_sdi_data  <= 8'h00;
      resp_ctr          <= 8'h00;
    end else begin
      bus.spi_sdi_valid <= bus.spi_cmd_valid && bus.spi_cmd_ready;
      bus.spi_sdi_data  <= resp_ctr;
      if (bus.spi_cmd_valid && bus.spi_cmd_ready) resp_ctr <= resp_ctr + 8'd1;
    end
  end

  // RDY pin: low for 10 of every 100 cycles while enabled.
  always @(posedge clk) begin
    if (!rdy_auto) begin
      rdy_cnt   <= 0;
      adc_rdy_n <= 1'b1;
    end else begin
      rdy_cnt   <= (rdy_cnt == 99) ? 0 : rdy_cnt + 1;
      adc_rdy_n <= (rdy_cnt >= 10);
    end
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      trig_n <= 0; done_n <= 0; buf_n <= 0; cmd_n <= 0; cmd42_n <= 0; overlap_n <= 0;
    end else begin
      if (bus.trigger) trig_n <= trig_n + 1;
      if (frame_done) done_n <= done_n + 1;
      if (bus.trigger && bus.buf_sdi_valid) overlap_n <= overlap_n + 1;
      if (bus.buf_sdi_valid) begin
        if (buf_n < 256) buf_log[buf_n] <= bus.buf_sdi_data;
        buf_n <= buf_n + 1;
      end
      if (bus.spi_cmd_valid && bus.spi_cmd_ready) begin
        if (cmd_n < 256) cmd_log[cmd_n] <= bus.spi_cmd_data;
        cmd_n <= cmd_n + 1;
        if (bus.spi_cmd_data == 8'h42) cmd42_n <= cmd42_n + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    ctrl_start = 1'b1;
    tick();
    ctrl_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    ctrl_enable = 1'b0;
    ctrl_continuous = 1'b0;
    ctrl_start = 1'b0;
    timeout_cycles = '0;
    ready_en = 1'b1;
    rdy_auto = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    do_reset();
    chk("rst_outputs", 32'({busy, frame_done, err_timeout, err_ch, bus.trigger,
                            bus.spi_cs_hold, bus.spi_cmd_valid, bus.buf_sdi_valid}), 32'd0);
    chk("rst_buf_data", 32'(bus.buf_sdi_data), 32'd0);

    // 1: single-shot frame
    ctrl_enable = 1'b1;
    rdy_auto = 1'b1;
    pulse_start();
    chk("t1_trigger_start", 32'(bus.trigger), 32'd1);
    wait_idle(3000, "t1_idle");
    repeat (2) tick();
    chk("t1_trig_n", 32'(trig_n), 32'd1);
    chk("t1_done_n", 32'(done_n), 32'd1);
    chk("t1_buf_n", 32'(buf_n), 32'd32);
    chk("t1_overlap", 32'(overlap_n), 32'd0);
    chk("t1_err_timeout", 32'(err_timeout), 32'd0);
    for (int k = 0; k < 32; k++) begin
      chk($sformatf("t1_byte%0d", k), 32'(buf_log[k]), 32'((k / 4) * 5 + (k % 4) + 1));
    end
    chk("t1_cmd_n", 32'(cmd_n), 32'd40);
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("t1_cmd%0d", i), 32'(cmd_log[i]), (i % 5 == 0) ? 32'h42 : 32'h00);
    end

    // 2: command held stable while ready is low
    do_reset();
    ctrl_enable = 1'b1;
    ready_en = 1'b0;
    rdy_auto = 1'b1;
    pulse_start();
    n = 0;
    while (bus.spi_cmd_valid !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t2_hold%0d", i), 32'({bus.spi_cmd_valid, bus.spi_cmd_data, bus.spi_cs_hold}),
          32'({1'b1, 8'h42, 1'b1}));
      tick();
    end
    chk("t2_no_accept", 32'(cmd_n), 32'd0);
    ready_en = 1'b1;
    wait_idle(3000, "t2_idle");
    chk("t2_cmd_n", 32'(cmd_n), 32'd40);
    chk("t2_buf_n", 32'(buf_n), 32'd32);

    // 3: RDY timeout at cycle 50 of WAIT_RDY
    do_reset();
    ctrl_enable = 1'b1;
    timeout_cycles = 20'd50;
    pulse_start();
    repeat (50) tick();
    chk("t3_before", 32'({err_timeout, busy}), 32'b01);
    tick();
    chk("t3_at", 32'({err_timeout, busy}), 32'b10);
    chk("t3_no_done", 32'(done_n), 32'd0);
    ctrl_enable = 1'b0;
    pulse_start();
    chk("t3_clear", 32'({err_timeout, busy}), 32'b00);

    // 4: continuous, three frames, then drop enable during channel 5
    do_reset();
    ctrl_enable = 1'b1;
    ctrl_continuous = 1'b1;
    rdy_auto = 1'b1;
    pulse_start();
    n = 0;
    while (done_n < 3 && n < 4000) begin
      tick();
      n++;
    end
    chk("t4_three_frames", 32'(done_n), 32'd3);
    chk("t4_trig_3", 32'(trig_n), 32'd3);
    chk("t4_buf_96", 32'(buf_n), 32'd96);
    n = 0;
    while (cmd42_n < 30 && n < 2000) begin
      tick();
      n++;
    end
    chk("t4_ch5_reached", 32'(cmd42_n), 32'd30);
    ctrl_enable = 1'b0;
    wait_idle(500, "t4_idle");
    repeat (2) tick();
    chk("t4_trig_n", 32'(trig_n), 32'd4);
    chk("t4_done_n", 32'(done_n), 32'd3);
    chk("t4_buf_n", 32'(buf_n), 32'd120);
    chk("t4_ch_n", 32'(cmd42_n), 32'd30);
    chk("t4_overlap", 32'(overlap_n), 32'd0);
`ifndef AXI_AD7124_SEQ_CH_CHECK_EN
    // 5: channel check disabled
    chk("t5_err_ch", 32'(err_ch), 32'd0);
`endif

    // 6: async reset mid-transaction, then clean restart
    do_reset();
    ctrl_enable = 1'b1;
    rdy_auto = 1'b1;
    pulse_start();
    n = 0;
    while (bus.spi_cs_hold !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk("t6_in_xact", 32'(bus.spi_cs_hold), 32'd1);
    resetn = 1'b0;
    #1;
    chk("t6_rst_outputs", 32'({busy, frame_done, err_timeout, bus.trigger, bus.spi_cs_hold,
                               bus.spi_cmd_valid, bus.buf_sdi_valid}), 32'd0);
    repeat (2) tick();
    resetn = 1'b1;
    tick();
    pulse_start();
    wait_idle(3000, "t6_idle");
    repeat (2) tick();
    chk("t6_trig_n", 32'(trig_n), 32'd1);
    chk("t6_buf_n", 32'(buf_n), 32'd32);
    chk("t6_done_n", 32'(done_n), 32'd1);
    chk("t6_byte0", 32'(buf_log[0]), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
